// File: rtl/acc_drain.sv
// ---------------------------------------------------------------------------
// acc_drain
//
// Drains the end-of-row accumulator chains of a ROWS x COLS PE array.
// A start request broadcasts a one-cycle shift_acc capture pulse to every PE.
// The controller then collects COLS words from each row chain into a local
// buffer and streams them out row-major over a valid/ready handshake.
//
// Each row chain delivers its words last column first. The first word that
// row r delivers is therefore its column COLS-1 value. Rows fill
// independently and may be skewed by any number of cycles.
//
// Ports:
//   clock          rising-edge clock
//   resetn         asynchronous active-low reset
//   start          single-cycle drain request (ignored while busy)
//   shift_acc      capture pulse to every PE (high for the single SHIFT cycle)
//   row_acc        end-of-row chain words, row r in bits [32r+31:32r]
//   row_acc_valid  per-row word valid
//   out_data       drained word
//   out_row        row index of out_data
//   out_col        column index of out_data
//   out_valid      out_data valid
//   out_ready      consumer accepts out_data
//   busy           high in every state except IDLE
//   done           one-cycle pulse after the last word is accepted
//   overflow       sticky: a row delivered more than COLS words
// ---------------------------------------------------------------------------
module acc_drain #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 start,
    output logic                 shift_acc,
    input  logic [32*ROWS-1:0]   row_acc,
    input  logic [ROWS-1:0]      row_acc_valid,
    output logic [31:0]          out_data,
    output logic [RW-1:0]        out_row,
    output logic [CW-1:0]        out_col,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);

    // Per-row word counters must be able to hold the value COLS itself.
    localparam int NW = $clog2(COLS + 1);
    localparam logic [NW-1:0] CNT_FULL = NW'(COLS);
    localparam logic [NW-1:0] CNT_LAST = NW'(COLS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        COLLECT = 2'd2,
        EMIT    = 2'd3
    } state_t;

    state_t          state;
    logic [NW-1:0]   count [ROWS];
    logic [31:0]     buffer [ROWS][COLS];

    logic [ROWS-1:0] wr_en;
    logic [ROWS-1:0] ovf_hit;
    logic [ROWS-1:0] full_next;
    logic [CW-1:0]   wr_col [ROWS];

    // Per-row collect control. Words are accepted only while collecting.
    // A word on a row that already holds COLS words is dropped and flagged.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            assign wr_en[gi]   = (state == COLLECT) && row_acc_valid[gi] &&
                                 (count[gi] != CNT_FULL);
            assign ovf_hit[gi] = (state == COLLECT) && row_acc_valid[gi] &&
                                 (count[gi] == CNT_FULL);
            // The chain delivers the highest column first.
            assign wr_col[gi]  = COL_LAST - CW'(count[gi]);
            // The row is complete after this edge, either already or by this write.
            assign full_next[gi] = (count[gi] == CNT_FULL) ||
                                   (wr_en[gi] && (count[gi] == CNT_LAST));
        end
    endgenerate

    // Word buffer. It is not reset; the counters decide what is valid.
    always_ff @(posedge clock) begin
        for (int r = 0; r < ROWS; r++) begin
            if (wr_en[r]) begin
                buffer[r][wr_col[r]] <= row_acc[32*r +: 32];
            end
        end
    end

    // EMIT is entered on the same edge that stores the final word.
    // That final word may be entry [0][0] (row 0's last delivery).
    // In that case it is forwarded straight into out_data.
    logic [31:0] first_word;
    assign first_word = (wr_en[0] && (wr_col[0] == '0)) ? row_acc[31:0]
                                                         : buffer[0][0];

    // Row-major index advance for the emit stream.
    logic          last_word;
    logic [RW-1:0] next_row;
    logic [CW-1:0] next_col;

    assign last_word = (out_row == ROW_LAST) && (out_col == COL_LAST);

    always_comb begin
        next_row = out_row;
        next_col = out_col + 1'b1;
        if (out_col == COL_LAST) begin
            next_col = '0;
            next_row = out_row + 1'b1;
        end
    end

    // Control FSM. All outputs are registered.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            shift_acc <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            for (int r = 0; r < ROWS; r++) begin
                count[r] <= '0;
            end
        end else begin
            done      <= 1'b0;
            shift_acc <= 1'b0;
            overflow  <= overflow | (|ovf_hit);

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SHIFT;
                        shift_acc <= 1'b1;
                        busy      <= 1'b1;
                    end
                end

                SHIFT: begin
                    for (int r = 0; r < ROWS; r++) begin
                        count[r] <= '0;
                    end
                    state <= COLLECT;
                end

                COLLECT: begin
                    for (int r = 0; r < ROWS; r++) begin
                        if (wr_en[r]) begin
                            count[r] <= count[r] + 1'b1;
                        end
                    end
                    if (&full_next) begin
                        state     <= EMIT;
                        out_valid <= 1'b1;
                        out_data  <= first_word;
                        out_row   <= '0;
                        out_col   <= '0;
                    end
                end

                EMIT: begin
                    if (out_ready) begin
                        if (last_word) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            out_data  <= '0;
                            out_row   <= '0;
                            out_col   <= '0;
                        end else begin
                            out_row  <= next_row;
                            out_col  <= next_col;
                            out_data <= buffer[next_row][next_col];
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_drain.sv
// ---------------------------------------------------------------------------
// tb_acc_drain
//
// Self-checking bench for acc_drain (ROWS = COLS = 4).
// The row drivers record every word they deliver. Once delivery is complete
// the expected stream is queued in row-major order. The emit side pops and
// compares each accepted word. Outputs are sampled and inputs driven on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_acc_drain;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int NWORDS = ROWS * COLS;

    logic                 clock;
    logic                 resetn;
    logic                 start;
    logic                 shift_acc;
    logic [32*ROWS-1:0]   row_acc;
    logic [ROWS-1:0]      row_acc_valid;
    logic [31:0]          out_data;
    logic [1:0]           out_row;
    logic [1:0]           out_col;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 done;
    logic                 overflow;

    acc_drain #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .start         (start),
        .shift_acc     (shift_acc),
        .row_acc       (row_acc),
        .row_acc_valid (row_acc_valid),
        .out_data      (out_data),
        .out_row       (out_row),
        .out_col       (out_col),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] d;
        int          r;
        int          c;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   shift_seen;
    int   early_valid_seen;

    function automatic logic [31:0] word_of(input int base, input int r, input int c);
        return 32'(base + 10 * r + c + 1);
    endfunction

    // Drive the row chains. Row r starts delay_r cycles into the call and
    // delivers columns COLS-1 down to 0 on consecutive cycles.
    // extra_row (if >= 0) sends one surplus word right after its fourth word.
    // start is pulsed at cycle start_at (if >= 0).
    // Returns on the falling edge after the final word, with valids cleared.
    task automatic drive_rows(input int base, input int d0, input int d1,
                              input int d2, input int d3,
                              input int extra_row, input int start_at);
        int dly[ROWS];
        int last_k;
        dly = '{d0, d1, d2, d3};
        last_k = 0;
        for (int r = 0; r < ROWS; r++) begin
            if (dly[r] + COLS - 1 > last_k) last_k = dly[r] + COLS - 1;
        end
        shift_seen = 0;
        early_valid_seen = 0;
        for (int k = 0; k <= last_k; k++) begin
            @(negedge clock);
            if (shift_acc) shift_seen++;
            if (out_valid) early_valid_seen++;
            start = (k == start_at);
            for (int r = 0; r < ROWS; r++) begin
                int idx;
                idx = k - dly[r];
                row_acc_valid[r] = 1'b0;
                row_acc[32*r +: 32] = 32'hBAD0_0000;
                if (idx >= 0 && idx < COLS) begin
                    row_acc_valid[r] = 1'b1;
                    row_acc[32*r +: 32] = word_of(base, r, COLS - 1 - idx);
                end else if (r == extra_row && idx == COLS) begin
                    row_acc_valid[r] = 1'b1;
                    row_acc[32*r +: 32] = 32'hDEAD_0000 + 32'(r);
                end
            end
        end
        @(negedge clock);
        row_acc_valid = '0;
        start = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                exp_t e;
                e.d = word_of(base, r, c);
                e.r = r;
                e.c = c;
                sb.push_back(e);
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({shift_acc, out_valid, busy, done, overflow} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000",
                     {shift_acc, out_valid, busy, done, overflow});
        else n_cmp += 0;
        if ({shift_acc, out_valid, busy, done, overflow} !== 5'b0) n_bad++;
        n_cmp++;
        if (out_data !== 32'd0 || out_row !== 2'd0 || out_col !== 2'd0) begin
            $display("FAIL reset_outputs: got data=%h row=%0d col=%0d want 0/0/0",
                     out_data, out_row, out_col);
            n_bad++;
        end
    endtask

    // Full-rate drain with start asserted on the first edge after reset release.
    task automatic test_basic();
        int  cyc;
        int  xfers;
        bit  got_done;
        exp_t e;
        @(negedge clock);
        resetn = 1'b1;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n_cmp++;
        if (shift_acc !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL basic_first_start: got shift_acc=%b busy=%b want 1 1", shift_acc, busy);
            n_bad++;
        end
        drive_rows(0, 1, 1, 1, 1, -1, -1);
        n_cmp++;
        if (shift_seen !== 0) begin
            $display("FAIL basic_shift_pulse: got %0d extra shift cycles want 0", shift_seen);
            n_bad++;
        end
        n_cmp++;
        if (out_valid !== 1'b1) begin
            $display("FAIL basic_emit_entry: got out_valid=%b want 1", out_valid);
            n_bad++;
        end
        cyc = 0; xfers = 0; got_done = 0;
        out_ready = 1'b1;
        while (cyc < 100) begin
            if (done) begin got_done = 1; break; end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL basic_extra_word: got %h want none", out_data);
                end else begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (out_data !== e.d || int'(out_row) != e.r || int'(out_col) != e.c) begin
                        $display("FAIL basic_word: got %h (%0d,%0d) want %h (%0d,%0d)",
                                 out_data, out_row, out_col, e.d, e.r, e.c);
                        n_bad++;
                    end
                end
                xfers++;
            end
            @(negedge clock);
            cyc++;
        end
        n_cmp++;
        if (!got_done || xfers != NWORDS || cyc != NWORDS || sb.size() != 0) begin
            $display("FAIL basic_count: got done=%0d xfers=%0d cycles=%0d left=%0d want 1 16 16 0",
                     got_done, xfers, cyc, sb.size());
            n_bad++;
        end
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL basic_done_state: got out_valid=%b busy=%b want 0 0", out_valid, busy);
            n_bad++;
        end
        // A start in the done cycle must be taken.
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || shift_acc !== 1'b1) begin
            $display("FAIL basic_restart: got done=%b shift_acc=%b want 0 1", done, shift_acc);
            n_bad++;
        end
    endtask

    // Row 3 lags rows 0-2 by 5 cycles. The drain was started in test_basic.
    task automatic test_skew();
        int  cyc;
        bit  got_done;
        exp_t e;
        drive_rows(200, 0, 0, 0, 5, -1, -1);
        n_cmp++;
        if (early_valid_seen != 0 || out_valid !== 1'b1) begin
            $display("FAIL skew_emit_timing: got early=%0d out_valid=%b want 0 1",
                     early_valid_seen, out_valid);
            n_bad++;
        end
        cyc = 0; got_done = 0;
        out_ready = 1'b1;
        while (cyc < 100) begin
            if (done) begin got_done = 1; break; end
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (out_data !== e.d || int'(out_row) != e.r || int'(out_col) != e.c) begin
                    $display("FAIL skew_word: got %h (%0d,%0d) want %h (%0d,%0d)",
                             out_data, out_row, out_col, e.d, e.r, e.c);
                    n_bad++;
                end
            end
            @(negedge clock);
            cyc++;
        end
        n_cmp++;
        if (!got_done || sb.size() != 0) begin
            $display("FAIL skew_complete: got done=%0d left=%0d want 1 0", got_done, sb.size());
            n_bad++;
        end
    endtask

    // out_ready follows 1,0,0,1,0,0,...
    task automatic test_backpressure();
        int  cyc;
        int  xfers;
        int  done_cnt;
        bit  stalled;
        logic [31:0] h_d;
        logic [1:0]  h_r;
        logic [1:0]  h_c;
        exp_t e;
        pulse_start();
        drive_rows(300, 0, 1, 2, 3, -1, -1);
        cyc = 0; xfers = 0; stalled = 0; done_cnt = 0;
        while (cyc < 200 && !done) begin
            out_ready = (cyc % 3 == 0);
            if (stalled) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== h_d || out_row !== h_r || out_col !== h_c) begin
                    $display("FAIL bp_stall_hold: got v=%b %h (%0d,%0d) want v=1 %h (%0d,%0d)",
                             out_valid, out_data, out_row, out_col, h_d, h_r, h_c);
                    n_bad++;
                end
            end
            stalled = out_valid && !out_ready;
            h_d = out_data; h_r = out_row; h_c = out_col;
            if (out_valid && out_ready) begin
                xfers++;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (out_data !== e.d || int'(out_row) != e.r || int'(out_col) != e.c) begin
                        $display("FAIL bp_word: got %h (%0d,%0d) want %h (%0d,%0d)",
                                 out_data, out_row, out_col, e.d, e.r, e.c);
                        n_bad++;
                    end
                end
            end
            @(negedge clock);
            cyc++;
        end
        n_cmp++;
        if (done !== 1'b1 || xfers != NWORDS || sb.size() != 0) begin
            $display("FAIL bp_count: got done=%b xfers=%0d left=%0d want 1 16 0",
                     done, xfers, sb.size());
            n_bad++;
        end
        // Words arriving while idle are dropped without flagging overflow.
        // done must also drop after exactly one cycle.
        for (int k = 0; k < 3; k++) begin
            if (done) done_cnt++;
            row_acc_valid = '1;
            @(negedge clock);
        end
        row_acc_valid = '0;
        n_cmp++;
        if (done_cnt != 1 || overflow !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL bp_idle_words: got done_cycles=%0d overflow=%b busy=%b want 1 0 0",
                     done_cnt, overflow, busy);
            n_bad++;
        end
        out_ready = 1'b1;
    endtask

    // Row 1 sends a fifth word and start is pulsed while collecting.
    task automatic test_overflow();
        int  cyc;
        int  xfers;
        exp_t e;
        pulse_start();
        drive_rows(400, 0, 0, 0, 5, 1, 2);
        n_cmp++;
        if (overflow !== 1'b1) begin
            $display("FAIL ovf_set: got %b want 1", overflow);
            n_bad++;
        end
        cyc = 0; xfers = 0;
        out_ready = 1'b1;
        while (cyc < 100 && !done) begin
            if (out_valid && out_ready) begin
                xfers++;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (out_data !== e.d || int'(out_row) != e.r || int'(out_col) != e.c) begin
                        $display("FAIL ovf_word: got %h (%0d,%0d) want %h (%0d,%0d)",
                                 out_data, out_row, out_col, e.d, e.r, e.c);
                        n_bad++;
                    end
                end
            end
            @(negedge clock);
            cyc++;
        end
        @(negedge clock);
        n_cmp++;
        if (xfers != NWORDS || overflow !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL ovf_after: got xfers=%0d overflow=%b busy=%b want 16 1 0",
                     xfers, overflow, busy);
            n_bad++;
        end
    endtask

    // Reset in the middle of EMIT, then a fresh drain.
    task automatic test_reset_mid_emit();
        int  cyc;
        int  xfers;
        int  bad_cycles;
        exp_t e;
        pulse_start();
        drive_rows(500, 0, 0, 0, 0, -1, -1);
        cyc = 0; xfers = 0;
        out_ready = 1'b1;
        while (cyc < 100 && xfers < 7) begin
            if (out_valid && out_ready) begin
                xfers++;
                e = sb.pop_front();
                n_cmp++;
                if (out_data !== e.d || int'(out_row) != e.r || int'(out_col) != e.c) begin
                    $display("FAIL rst_pre_word: got %h (%0d,%0d) want %h (%0d,%0d)",
                             out_data, out_row, out_col, e.d, e.r, e.c);
                    n_bad++;
                end
            end
            @(negedge clock);
            cyc++;
        end
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({shift_acc, out_valid, busy, done, overflow} !== 5'b0 ||
            out_data !== 32'd0 || out_row !== 2'd0 || out_col !== 2'd0) begin
            $display("FAIL rst_async: got flags=%b data=%h row=%0d col=%0d want all 0",
                     {shift_acc, out_valid, busy, done, overflow}, out_data, out_row, out_col);
            n_bad++;
        end
        sb.delete();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        bad_cycles = 0;
        repeat (5) begin
            @(negedge clock);
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) bad_cycles++;
        end
        n_cmp++;
        if (bad_cycles != 0) begin
            $display("FAIL rst_no_done: got %0d cycles with done/busy/valid set want 0", bad_cycles);
            n_bad++;
        end
        pulse_start();
        drive_rows(600, 2, 0, 1, 0, -1, -1);
        cyc = 0; xfers = 0;
        while (cyc < 100 && !done) begin
            if (out_valid && out_ready) begin
                xfers++;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    n_cmp++;
                    if (out_data !== e.d || int'(out_row) != e.r || int'(out_col) != e.c) begin
                        $display("FAIL rst_post_word: got %h (%0d,%0d) want %h (%0d,%0d)",
                                 out_data, out_row, out_col, e.d, e.r, e.c);
                        n_bad++;
                    end
                end
            end
            @(negedge clock);
            cyc++;
        end
        n_cmp++;
        if (done !== 1'b1 || xfers != NWORDS) begin
            $display("FAIL rst_post_count: got done=%b xfers=%0d want 1 16", done, xfers);
            n_bad++;
        end
    endtask

    initial begin
        resetn        = 1'b0;
        start         = 1'b0;
        row_acc       = '0;
        row_acc_valid = '0;
        out_ready     = 1'b0;
        test_reset();
        test_basic();
        test_skew();
        test_backpressure();
        test_overflow();
        test_reset_mid_emit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
